// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard/forwarding/dmem-handshake signal bundle between datapath and hazard_ctrl.
// Ports: ID/EX/MEM/WB register addresses and write enables, dmem req/ack in; holds, flush, bubble,
//        forwarding selects, dmem_valid, mem_err and stall_cnt out. slave = controller, master = datapath.
interface hazard_ctrl_if;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ex_rs_addr;
  logic [4:0]  ex_rt_addr;
  logic        ex_memread;
  logic        ex_regwr;
  logic [4:0]  ex_regdst_addr;
  logic        ex_branch_taken;
  logic        mem_regwr;
  logic [4:0]  mem_regdst_addr;
  logic        wr_regwr;
  logic [4:0]  wr_regdst_addr;
  logic        mem_req;
  logic        dmem_ack;
  logic        dmem_valid;
  logic        pa_pc;
  logic        pa_ifid;
  logic        pa_idex;
  logic        pa_idexmemwr;
  logic        flush_ifid;
  logic        bubble_idex;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        mem_err;
  logic [31:0] stall_cnt;

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
    input  ex_rs_addr, ex_rt_addr, ex_memread, ex_regwr, ex_regdst_addr, ex_branch_taken,
    input  mem_regwr, mem_regdst_addr, wr_regwr, wr_regdst_addr, mem_req, dmem_ack,
    output dmem_valid, pa_pc, pa_ifid, pa_idex, pa_idexmemwr, flush_ifid, bubble_idex,
    output fwd_a_sel, fwd_b_sel, mem_err, stall_cnt
  );

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
    output ex_rs_addr, ex_rt_addr, ex_memread, ex_regwr, ex_regdst_addr, ex_branch_taken,
    output mem_regwr, mem_regdst_addr, wr_regwr, wr_regdst_addr, mem_req, dmem_ack,
    input  dmem_valid, pa_pc, pa_ifid, pa_idex, pa_idexmemwr, flush_ifid, bubble_idex,
    input  fwd_a_sel, fwd_b_sel, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: stall/flush/bubble, EX forwarding selects, dmem handshake + watchdog.
// Ports: clk, reset (sync, active-high), hz (hazard_ctrl_if.slave). Control outputs are zero-latency
//        combinational; a pending dmem access holds the whole pipeline until ack, timeout or reset.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] stall_cnt_q;
  logic        mem_err_q;

  logic mem_stall;
  logic load_use;
  logic pa_all;

  assign mem_stall = hz.mem_req & ~hz.dmem_ack & (state != S_ERR);

  assign load_use = hz.ex_memread & hz.ex_regwr & (hz.ex_regdst_addr != 5'd0) &
                    ((hz.id_uses_rs & (hz.id_rs_addr == hz.ex_regdst_addr)) |
                     (hz.id_uses_rt & (hz.id_rt_addr == hz.ex_regdst_addr)));

  // MEM result is younger than WB, so it wins; r0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hz.mem_regwr && hz.mem_regdst_addr != 5'd0 && hz.mem_regdst_addr == src)
      return 2'b01;
    else if (hz.wr_regwr && hz.wr_regdst_addr != 5'd0 && hz.wr_regdst_addr == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign pa_all = (state == S_ERR) | mem_stall;

  always_comb begin
    hz.pa_pc        = 1'b0;
    hz.pa_ifid      = 1'b0;
    hz.pa_idex      = 1'b0;
    hz.pa_idexmemwr = 1'b0;
    hz.flush_ifid   = 1'b0;
    hz.bubble_idex  = 1'b0;
    hz.dmem_valid   = 1'b0;
    hz.fwd_a_sel    = 2'b00;
    hz.fwd_b_sel    = 2'b00;
    if (!reset) begin
      if (pa_all) begin
        hz.pa_pc        = 1'b1;
        hz.pa_ifid      = 1'b1;
        hz.pa_idex      = 1'b1;
        hz.pa_idexmemwr = 1'b1;
      end else if (hz.ex_branch_taken) begin
        // Delay slot in ID proceeds; only the wrong-path fetch in IF is squashed.
        hz.flush_ifid = 1'b1;
      end else if (load_use) begin
        hz.pa_pc       = 1'b1;
        hz.pa_ifid     = 1'b1;
        hz.bubble_idex = 1'b1;
      end
      // Strobe stays up through WAIT even if the datapath drops mem_req.
      hz.dmem_valid = (state == S_RUN) ? hz.mem_req : (state == S_WAIT);
      hz.fwd_a_sel  = fwd_sel(hz.ex_rs_addr);
      hz.fwd_b_sel  = fwd_sel(hz.ex_rt_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      wait_cnt    <= 16'd0;
      stall_cnt_q <= 32'd0;
      mem_err_q   <= 1'b0;
    end else begin
      if (hz.pa_pc && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      case (state)
        S_RUN: begin
          if (mem_stall) begin
            state    <= S_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        S_WAIT: begin
          // Ack is checked first so a late ack on the final tolerated cycle still completes.
          if (hz.dmem_ack) begin
            state    <= S_RUN;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == 16'(TIMEOUT)) begin
            state     <= S_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for combinational decode, directed sequences
// for the multi-cycle load-use, dmem wait, timeout/ERR, ack-at-timeout and reset cases.
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_ctrl_if hz();

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       uses_rs, uses_rt;
    logic [4:0] ex_rs, ex_rt;
    logic       memread, regwr;
    logic [4:0] ex_dst;
    logic       br;
    logic       mem_regwr;
    logic [4:0] mem_dst;
    logic       wr_regwr;
    logic [4:0] wr_dst;
    logic       mem_req, ack;
    // {pa_pc, pa_ifid, pa_idex, pa_idexmemwr, flush, bubble, dmem_valid, fwd_a[1:0], fwd_b[1:0]}
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [10:0] outs();
    return {hz.pa_pc, hz.pa_ifid, hz.pa_idex, hz.pa_idexmemwr, hz.flush_ifid,
            hz.bubble_idex, hz.dmem_valid, hz.fwd_a_sel, hz.fwd_b_sel};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    hz.id_rs_addr      = v.id_rs;
    hz.id_rt_addr      = v.id_rt;
    hz.id_uses_rs      = v.uses_rs;
    hz.id_uses_rt      = v.uses_rt;
    hz.ex_rs_addr      = v.ex_rs;
    hz.ex_rt_addr      = v.ex_rt;
    hz.ex_memread      = v.memread;
    hz.ex_regwr        = v.regwr;
    hz.ex_regdst_addr  = v.ex_dst;
    hz.ex_branch_taken = v.br;
    hz.mem_regwr       = v.mem_regwr;
    hz.mem_regdst_addr = v.mem_dst;
    hz.wr_regwr        = v.wr_regwr;
    hz.wr_regdst_addr  = v.wr_dst;
    hz.mem_req         = v.mem_req;
    hz.dmem_ack        = v.ack;
  endtask

  task automatic clr();
    vec_t z;
    z = '{default: 0};
    apply(z);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    cyc();
    clr();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t lu;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;

    // Load-use on rt: r5 loaded in EX, read in ID.
    lu = '{default: 0};
    lu.id_rt = 5'd5; lu.uses_rt = 1'b1; lu.memread = 1'b1; lu.regwr = 1'b1; lu.ex_dst = 5'd5;

    v = '{default: 0};                                   vq.push_back(v);
    v = lu; v.exp = 11'b110001_0_0000;                   vq.push_back(v);
    v = lu; v.id_rt = 5'd0; v.ex_dst = 5'd0;             vq.push_back(v);
    v = lu; v.uses_rt = 1'b0;                            vq.push_back(v);
    v = '{default: 0}; v.id_rs = 5'd9; v.uses_rs = 1'b1; v.memread = 1'b1; v.regwr = 1'b1;
    v.ex_dst = 5'd9; v.exp = 11'b110001_0_0000;          vq.push_back(v);
    v = lu; v.regwr = 1'b0;                              vq.push_back(v);
    v = '{default: 0}; v.mem_regwr = 1'b1; v.mem_dst = 5'd7; v.wr_regwr = 1'b1; v.wr_dst = 5'd7;
    v.ex_rs = 5'd7; v.exp = 11'b000000_0_0100;           vq.push_back(v);
    v.mem_regwr = 1'b0; v.exp = 11'b000000_0_1000;       vq.push_back(v);
    v = '{default: 0}; v.mem_regwr = 1'b1; v.wr_regwr = 1'b1;
    v.exp = 11'b000000_0_0000;                           vq.push_back(v);
    v = '{default: 0}; v.ex_rt = 5'd3; v.mem_regwr = 1'b1; v.mem_dst = 5'd3;
    v.ex_rs = 5'd4; v.wr_regwr = 1'b1; v.wr_dst = 5'd4; v.exp = 11'b000000_0_1001; vq.push_back(v);
    v = lu; v.br = 1'b1; v.exp = 11'b000010_0_0000;      vq.push_back(v);
    v = '{default: 0}; v.mem_req = 1'b1; v.ack = 1'b1; v.exp = 11'b000000_1_0000; vq.push_back(v);
    v.br = 1'b1; v.exp = 11'b000010_1_0000;              vq.push_back(v);

    // Reset: outputs forced low even with a load-use hazard on the inputs.
    apply(lu);
    cyc(); cyc();
    settle();
    chk("reset_outs_forced_0", {21'd0, outs()}, 32'd0);
    cyc();
    reset = 1'b0;
    clr();
    settle();
    chk("reset_stall_cnt", hz.stall_cnt, 32'd0);
    chk("reset_mem_err", {31'd0, hz.mem_err}, 32'd0);

    // Combinational decode table, one vector per cycle, always leaving the FSM in RUN.
    foreach (vq[i]) begin
      cyc();
      apply(vq[i]);
      settle();
      chk($sformatf("vec%0d", i), {21'd0, outs()}, {21'd0, vq[i].exp});
    end

    // Load-use costs exactly one cycle.
    do_reset();
    apply(lu);
    settle();
    chk("lu_stall", {21'd0, outs()}, {21'd0, 11'b110001_0_0000});
    cyc();
    clr();
    settle();
    chk("lu_release", {21'd0, outs()}, 32'd0);
    chk("lu_stall_cnt", hz.stall_cnt, 32'd1);

    // dmem ack on the 3rd request cycle: 2 held cycles, strobe for 3.
    do_reset();
    hz.mem_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("mw_hold%0d", c), {21'd0, outs()}, {21'd0, 11'b111100_1_0000});
      cyc();
    end
    hz.dmem_ack = 1'b1;
    settle();
    chk("mw_ack_cycle", {21'd0, outs()}, {21'd0, 11'b000000_1_0000});
    cyc();
    clr();
    settle();
    chk("mw_back_run", {21'd0, outs()}, 32'd0);
    chk("mw_stall_cnt", hz.stall_cnt, 32'd2);

    // Branch loses to a memory stall.
    do_reset();
    hz.mem_req = 1'b1; hz.ex_branch_taken = 1'b1;
    settle();
    chk("br_vs_memstall", {21'd0, outs()}, {21'd0, 11'b111100_1_0000});
    cyc();
    hz.dmem_ack = 1'b1;
    cyc();
    clr();

    // Watchdog: TIMEOUT=4 -> 5 stalled cycles, then ERR.
    do_reset();
    hz.mem_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("to_stall%0d", c), {20'd0, hz.mem_err, outs()}, {20'd0, 12'b0_111100_1_0000});
      cyc();
    end
    settle();
    chk("to_err_outs", {20'd0, hz.mem_err, outs()}, {20'd0, 12'b1_111100_0_0000});
    chk("to_err_stall_cnt", hz.stall_cnt, 32'd5);
    cyc();
    settle();
    chk("to_err_stall_cnt_inc", hz.stall_cnt, 32'd6);
    reset = 1'b1;
    settle();
    chk("to_reset_outs", {21'd0, outs()}, 32'd0);
    cyc();
    reset = 1'b0;
    hz.mem_req = 1'b0;
    settle();
    chk("to_reset_mem_err", {20'd0, hz.mem_err, outs()}, 32'd0);
    chk("to_reset_stall_cnt", hz.stall_cnt, 32'd0);

    // Ack on the same cycle wait_cnt reaches TIMEOUT: back to RUN, no error.
    do_reset();
    hz.mem_req = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    hz.dmem_ack = 1'b1;
    settle();
    chk("at_ack_outs", {21'd0, outs()}, {21'd0, 11'b000000_1_0000});
    cyc();
    clr();
    settle();
    chk("at_run_no_err", {20'd0, hz.mem_err, outs()}, 32'd0);
    chk("at_stall_cnt", hz.stall_cnt, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It generates the per-register hold signals (`pa_pc`, `pa_ifid`, `pa_idex`, `pa_idexmemwr`), the IF/ID flush and the ID/EX bubble. It also produces the EX-stage forwarding selects and runs the data-memory request/acknowledge handshake, including a wait-timeout watchdog. It sits beside the datapath and drives every pipeline register, including the MEM/WB register's `pa_idexmemwr` hold input.

## Interface
- `TIMEOUT`, 255: number of WAIT-state cycles without `dmem_ack` tolerated before entering ERR. Legal range is 1..65535.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `id_rs_addr`, `id_rt_addr`  in  5 each  source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1 each  ID instruction actually reads rs / rt
- `ex_rs_addr`, `ex_rt_addr`  in  5 each  source registers of the instruction in EX
- `ex_memread`, `ex_regwr`  in  1 each  EX instruction is a load / writes a register
- `ex_regdst_addr`  in  5  EX destination register
- `ex_branch_taken`  in  1  branch or jump resolved taken in EX
- `mem_regwr`, `mem_regdst_addr`  in  1 / 5  MEM-stage writeback info
- `wr_regwr`, `wr_regdst_addr`  in  1 / 5  WB-stage writeback info
- `mem_req`  in  1  MEM instruction is a load or store
- `dmem_ack`  in  1  data memory completes the access this cycle
- `dmem_valid`  out  1  request strobe to data memory
- `pa_pc`, `pa_ifid`, `pa_idex`, `pa_idexmemwr`  out  1 each  hold the PC / IF/ID / ID/EX / EX/MEM+MEM/WB registers (1 = hold)
- `flush_ifid`  out  1  load a NOP into IF/ID
- `bubble_idex`  out  1  load a NOP into ID/EX
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  EX operand source: 00 regfile, 01 MEM result, 10 WB result
- `mem_err`  out  1  watchdog tripped
- `stall_cnt`  out  32  saturating count of cycles with `pa_pc` = 1

## Operation
FSM states: RUN, WAIT, ERR. Encoding is free.

Condition terms:
- `mem_stall` = `mem_req` & ~`dmem_ack` & (state is RUN or WAIT).
- `load_use` = `ex_memread` & `ex_regwr` & (`ex_regdst_addr` != 0) & ((`id_uses_rs` & `id_rs_addr` == `ex_regdst_addr`) | (`id_uses_rt` & `id_rt_addr` == `ex_regdst_addr`)).

Cause priority and resulting outputs:
- ERR: all four `pa_*` = 1; `flush_ifid` = `bubble_idex` = 0; `dmem_valid` = 0; `mem_err` = 1.
- `mem_stall`: all four `pa_*` = 1; no flush, no bubble.
- `ex_branch_taken`: `flush_ifid` = 1, all `pa_*` = 0. The ID instruction (delay slot) proceeds.
- `load_use`: `pa_pc` = `pa_ifid` = 1, `bubble_idex` = 1, `pa_idex` = `pa_idexmemwr` = 0.
- Otherwise all outputs 0.
- Branch and `load_use` cannot coincide, because a load is not a branch. If both are asserted, branch wins.

Forwarding (combinational, independent of stalls):
- `fwd_a_sel` = 01 if `mem_regwr` & `mem_regdst_addr` != 0 & `mem_regdst_addr` == `ex_rs_addr`.
- Otherwise `fwd_a_sel` = 10 if the same condition holds with the `wr_*` signals.
- Otherwise `fwd_a_sel` = 00.
- MEM takes priority over WB. `fwd_b_sel` follows the same rules using `ex_rt_addr`. Register 0 is never forwarded.

Handshake:
- `dmem_valid` = `mem_req` in RUN. It is held at 1 in WAIT. It is 0 in ERR.
- RUN with `mem_stall` goes to WAIT; `wait_cnt` <= 1.
- WAIT with `dmem_ack` goes to RUN. That cycle has no mem stall, so the pipeline advances and captures the data.
- WAIT without ack: if `wait_cnt` == `TIMEOUT`, go to ERR; else `wait_cnt` increments.
- Ack wins over timeout in the same cycle.
- ERR is left only by `reset`.

## Timing
- Reset (`reset` high at a clock edge): state RUN, `wait_cnt` = 0, `stall_cnt` = 0, `mem_err` = 0.
- While `reset` is high, every control output (`pa_*`, flush, bubble, `dmem_valid`, `fwd_*`) is forced to 0.
- Reset during WAIT or ERR aborts the access. `dmem_valid` is 0 from the reset cycle onward.
- All control outputs are combinational from the inputs and the current state; there is zero-cycle latency.
- `load_use` costs exactly 1 stall cycle. A taken branch costs 1 flushed slot.
- A memory access acked in the request cycle costs 0 stall cycles. Otherwise the stall equals the number of cycles before ack.
- The ERR transition occurs after `TIMEOUT`+1 consecutive stalled cycles without ack.
- `stall_cnt` increments on each clock edge where `pa_pc` = 1, including ERR cycles. It saturates at 0xFFFFFFFF.

## Test plan
- Load `r5` in EX, ID reads `r5` via rt with `id_uses_rt` = 1 → one cycle of `pa_pc` = `pa_ifid` = `bubble_idex` = 1, `pa_idex` = 0. Next cycle all 0; `stall_cnt` = 1. Repeat with `ex_regdst_addr` = 0 → no stall.
- `mem_regdst_addr` = `wr_regdst_addr` = 7, both with regwr = 1, `ex_rs_addr` = 7 → `fwd_a_sel` = 01. Drop `mem_regwr` → 10. Set all addresses to 0 → 00.
- `mem_req` = 1, ack arrives on the 3rd cycle → `pa_*` = 1 for 2 cycles; `dmem_valid` = 1 for 3 cycles; state returns to RUN; `stall_cnt` = 2.
- `TIMEOUT` = 4, `mem_req` = 1, ack never arrives → 5 stalled cycles, then ERR with `mem_err` = 1, `dmem_valid` = 0, `pa_*` = 1. `reset` → all outputs 0, `mem_err` = 0.
- `ex_branch_taken` together with `load_use` → `flush_ifid` = 1, `bubble_idex` = 0, `pa_*` = 0. Branch together with `mem_stall` → `pa_*` = 1, `flush_ifid` = 0.
- Ack arriving in the same cycle `wait_cnt` == `TIMEOUT` → state RUN, `mem_err` stays 0.
